// File: rtl/softmax_result_checker.sv
// Softmax result checker: captures one probability vector, scans one lane per cycle to
// sum it and check it against 1.0 within TOL; argmax tracking is built only with SOFTMAX_CHK_ARGMAX_EN.
module softmax_result_checker #(
    parameter int          N   = 64,
    parameter logic [15:0] TOL = 16'd512,
    localparam int         IW  = $clog2(N),
    localparam int         SW  = 16 + IW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [N*16-1:0] prob_flat,
    output logic            busy,
    output logic            done,
    output logic [SW-1:0]   sum_out,
    output logic            sum_ok,
    output logic [IW-1:0]   max_idx,
    output logic [15:0]     max_val,
    output logic            overrun,
    output logic [15:0]     result_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [IW-1:0] LAST_LANE = IW'(N - 1);
    localparam logic [SW-1:0] ONE       = SW'(16'h8000);

    state_t          state_q, state_d;
    logic [15:0]     cap_q [N];
    logic [SW-1:0]   acc_q;
    logic [IW-1:0]   lane_q;
    logic [15:0]     lane_val;
    logic [SW-1:0]   diff_d;
    logic            sum_ok_d;
    logic            done_q;
    logic            sum_ok_q;
    logic            overrun_q;
    logic [SW-1:0]   sum_q;
    logic [15:0]     count_q;

    assign lane_val = cap_q[lane_q];

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (valid_in) state_d = SCAN;
            SCAN:    if (lane_q == LAST_LANE) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        diff_d = '0;
        if (acc_q >= ONE) diff_d = acc_q - ONE;
        else              diff_d = ONE - acc_q;
        sum_ok_d = (diff_d <= SW'(TOL));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: the capture buffer is reset explicitly; it is small enough to live in flops, not a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) cap_q[i] <= '0;
        end else if (state_q == IDLE && valid_in) begin
            for (int i = 0; i < N; i++) cap_q[i] <= prob_flat[16*i +: 16];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            lane_q    <= '0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            sum_ok_q  <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && valid_in) overrun_q <= 1'b1;
            case (state_q)
                IDLE: if (valid_in) begin
                    acc_q  <= '0;
                    lane_q <= '0;
                end
                SCAN: begin
                    acc_q  <= acc_q + SW'(lane_val);
                    lane_q <= lane_q + 1'b1;
                end
                DONE: begin
                    done_q   <= 1'b1;
                    sum_q    <= acc_q;
                    sum_ok_q <= sum_ok_d;
                    if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef SOFTMAX_CHK_ARGMAX_EN
    logic [15:0]   run_max_q, res_val_q;
    logic [IW-1:0] run_idx_q, res_idx_q;

    // Strict compare keeps the lowest index on ties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_max_q <= '0;
            run_idx_q <= '0;
            res_val_q <= '0;
            res_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (valid_in) begin
                    run_max_q <= '0;
                    run_idx_q <= '0;
                end
                SCAN: if (lane_val > run_max_q) begin
                    run_max_q <= lane_val;
                    run_idx_q <= lane_q;
                end
                DONE: begin
                    res_val_q <= run_max_q;
                    res_idx_q <= run_idx_q;
                end
                default: ;
            endcase
        end
    end

    assign max_idx = res_idx_q;
    assign max_val = res_val_q;
`else
    assign max_idx = '0;
    assign max_val = '0;
`endif

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign sum_out      = sum_q;
    assign sum_ok       = sum_ok_q;
    assign overrun      = overrun_q;
    assign result_count = count_q;

endmodule
